// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline hazard/stall controller.
package pipeline_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } pc_state_e;

  // Bit of the EX load code that marks a memory read.
  localparam int unsigned LOAD_FLAG_BIT = 3;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned MEM_READ_W    = 4;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational load-use hazard detection between the EX load and the ID operands.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_is_load_i,
  output logic                  load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real producer, so a load to it never creates a hazard.
  always_comb begin
    rs1_hit    = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit    = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
    load_use_o = ex_is_load_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller: load-use stall, branch flush and
// multi-cycle divide stall (RUN / MD_WAIT FSM, Mealy outputs).
// Optional performance counters: define PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_controller
  import pipeline_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_RS1_ADDR,
  input  logic [REG_ADDR_W-1:0] ID_RS2_ADDR,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] EX_REG_WRITE_ADDR,
  input  logic [MEM_READ_W-1:0] EX_DATA_MEM_READ,
  input  logic                  EX_BRANCH_TAKEN,
  input  logic                  EX_MULDIV_START,
  input  logic                  MULDIV_DONE,
  output logic                  PC_HOLD,
  output logic                  IF_ID_HOLD,
  output logic                  ID_EX_HOLD,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_FLUSH,
  output logic                  EX_MEM_BUBBLE,
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  output logic [31:0]           STALL_CYCLES,
  output logic [31:0]           FLUSH_EVENTS,
`endif
  output logic                  MULDIV_BUSY
);

  pc_state_e state_q, state_d;
  logic      load_use;

  // Only the load flag of the load code matters here.
  logic unused_mem_read_bits;
  assign unused_mem_read_bits =
    ^(EX_DATA_MEM_READ & ~(4'b0001 << LOAD_FLAG_BIT));

  hazard_detect u_hazard_detect (
    .id_rs1_addr_i (ID_RS1_ADDR),
    .id_rs2_addr_i (ID_RS2_ADDR),
    .id_uses_rs1_i (ID_USES_RS1),
    .id_uses_rs2_i (ID_USES_RS2),
    .ex_rd_addr_i  (EX_REG_WRITE_ADDR),
    .ex_is_load_i  (EX_DATA_MEM_READ[LOAD_FLAG_BIT]),
    .load_use_o    (load_use)
  );

  // State register; reset always returns to RUN.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state and Mealy outputs; a taken branch outranks a load-use stall
  // because the ID instruction is on the wrong path.
  always_comb begin
    state_d       = state_q;
    PC_HOLD       = 1'b0;
    IF_ID_HOLD    = 1'b0;
    ID_EX_HOLD    = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    MULDIV_BUSY   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (EX_BRANCH_TAKEN) begin
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end else if (EX_MULDIV_START && !MULDIV_DONE) begin
          PC_HOLD       = 1'b1;
          IF_ID_HOLD    = 1'b1;
          ID_EX_HOLD    = 1'b1;
          EX_MEM_BUBBLE = 1'b1;
          state_d       = ST_MD_WAIT;
        end else if (load_use) begin
          PC_HOLD     = 1'b1;
          IF_ID_HOLD  = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        if (MULDIV_DONE) begin
          state_d = ST_RUN;
        end else begin
          PC_HOLD       = 1'b1;
          IF_ID_HOLD    = 1'b1;
          ID_EX_HOLD    = 1'b1;
          EX_MEM_BUBBLE = 1'b1;
          MULDIV_BUSY   = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (RESET) begin
      state_d       = ST_RUN;
      PC_HOLD       = 1'b0;
      IF_ID_HOLD    = 1'b0;
      ID_EX_HOLD    = 1'b0;
      IF_ID_FLUSH   = 1'b0;
      ID_EX_FLUSH   = 1'b0;
      EX_MEM_BUBBLE = 1'b0;
      MULDIV_BUSY   = 1'b0;
    end
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  // Event counters, wrapping naturally at 32 bits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (PC_HOLD)     stall_cycles_q <= stall_cycles_q + 32'd1;
      if (IF_ID_FLUSH) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign STALL_CYCLES = stall_cycles_q;
  assign FLUSH_EVENTS = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller.
module tb_pipeline_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] ID_RS1_ADDR, ID_RS2_ADDR, EX_REG_WRITE_ADDR;
  logic       ID_USES_RS1, ID_USES_RS2;
  logic [3:0] EX_DATA_MEM_READ;
  logic       EX_BRANCH_TAKEN, EX_MULDIV_START, MULDIV_DONE;
  logic       PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, IF_ID_FLUSH, ID_EX_FLUSH;
  logic       EX_MEM_BUBBLE, MULDIV_BUSY;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [31:0] STALL_CYCLES, FLUSH_EVENTS;
`endif

  int errors = 0;
  int checks = 0;

  // Output order: {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_BUBBLE, MULDIV_BUSY}
  logic [6:0] outs;
  assign outs = {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, IF_ID_FLUSH, ID_EX_FLUSH,
                 EX_MEM_BUBBLE, MULDIV_BUSY};

  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_LOAD  = 7'b1100100;
  localparam logic [6:0] O_BR    = 7'b0001100;
  localparam logic [6:0] O_MD0   = 7'b1110010;
  localparam logic [6:0] O_MDW   = 7'b1110011;

  pipeline_controller dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .ID_RS1_ADDR       (ID_RS1_ADDR),
    .ID_RS2_ADDR       (ID_RS2_ADDR),
    .ID_USES_RS1       (ID_USES_RS1),
    .ID_USES_RS2       (ID_USES_RS2),
    .EX_REG_WRITE_ADDR (EX_REG_WRITE_ADDR),
    .EX_DATA_MEM_READ  (EX_DATA_MEM_READ),
    .EX_BRANCH_TAKEN   (EX_BRANCH_TAKEN),
    .EX_MULDIV_START   (EX_MULDIV_START),
    .MULDIV_DONE       (MULDIV_DONE),
    .PC_HOLD           (PC_HOLD),
    .IF_ID_HOLD        (IF_ID_HOLD),
    .ID_EX_HOLD        (ID_EX_HOLD),
    .IF_ID_FLUSH       (IF_ID_FLUSH),
    .ID_EX_FLUSH       (ID_EX_FLUSH),
    .EX_MEM_BUBBLE     (EX_MEM_BUBBLE),
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    .STALL_CYCLES      (STALL_CYCLES),
    .FLUSH_EVENTS      (FLUSH_EVENTS),
`endif
    .MULDIV_BUSY       (MULDIV_BUSY)
  );

  always #5 CLK = ~CLK;

  // Move to the next cycle: inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Drive one cycle's worth of inputs (not a checker).
  task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic br, input logic st, input logic dn);
    EX_DATA_MEM_READ  = ld ? 4'b1010 : 4'b0010;
    EX_REG_WRITE_ADDR = rd;
    ID_RS1_ADDR       = rs1;
    ID_USES_RS1       = u1;
    ID_RS2_ADDR       = rs2;
    ID_USES_RS2       = u2;
    EX_BRANCH_TAKEN   = br;
    EX_MULDIV_START   = st;
    MULDIV_DONE       = dn;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    next_cycle();
    // Inputs that would otherwise stall and flush.
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs, O_IDLE);
    end
    next_cycle();
    RESET = 1'b0;
    idle();
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected %b", outs, O_IDLE);
    end
  endtask

  task automatic test_load_use();
    // V1: load x5, ID reads x5 via rs2.
    next_cycle();
    drive(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_LOAD) begin
      errors++;
      $display("FAIL v1_load_use_rs2: got %b expected %b", outs, O_LOAD);
    end
    next_cycle();
    idle();
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL v1_after_stall: got %b expected %b", outs, O_IDLE);
    end
    // rs1 match but rs1 not used -> no stall.
    next_cycle();
    drive(1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL rs1_unused: got %b expected %b", outs, O_IDLE);
    end
    // rs1 match and used -> stall.
    next_cycle();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_LOAD) begin
      errors++;
      $display("FAIL rs1_used: got %b expected %b", outs, O_LOAD);
    end
    // Matching rd but not a load -> no stall.
    next_cycle();
    drive(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL not_load: got %b expected %b", outs, O_IDLE);
    end
    // V2: load to x0 -> no stall.
    next_cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL v2_rd_zero: got %b expected %b", outs, O_IDLE);
    end
  endtask

  task automatic test_branch();
    // V3: load-use plus taken branch -> flush only.
    next_cycle();
    drive(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (outs !== O_BR) begin
      errors++;
      $display("FAIL v3_branch_over_load: got %b expected %b", outs, O_BR);
    end
    next_cycle();
    idle();
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL v3_after_flush: got %b expected %b", outs, O_IDLE);
    end
  endtask

  task automatic test_divide();
    // V4: START at cycle 0, DONE at cycle 33.
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outs !== O_MD0) begin
      errors++;
      $display("FAIL v4_cycle0: got %b expected %b", outs, O_MD0);
    end
    for (int c = 1; c <= 32; c++) begin
      next_cycle();
      // Branch and load-use on cycle 5 must be ignored while waiting.
      if (c == 5) drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      else        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (outs !== O_MDW) begin
        errors++;
        $display("FAIL v4_wait_cycle%0d: got %b expected %b", c, outs, O_MDW);
      end
    end
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL v4_cycle33_release: got %b expected %b", outs, O_IDLE);
    end
    // Cycle 34: a load-use stall only appears in RUN.
    next_cycle();
    drive(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_LOAD) begin
      errors++;
      $display("FAIL v4_cycle34_run: got %b expected %b", outs, O_LOAD);
    end
  endtask

  task automatic test_reset_in_wait();
    // V5: reset at cycle 10 of a divide stall.
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (outs !== O_MDW) begin
      errors++;
      $display("FAIL v5_waiting: got %b expected %b", outs, O_MDW);
    end
    next_cycle();
    RESET = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL v5_during_reset: got %b expected %b", outs, O_IDLE);
    end
    next_cycle();
    RESET = 1'b0;
    idle();
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL v5_after_reset: got %b expected %b", outs, O_IDLE);
    end
    // START and DONE together -> no stall, stays in RUN.
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL v5_start_done: got %b expected %b", outs, O_IDLE);
    end
    // Still in RUN: a fresh start shows the cycle-0 pattern (no BUSY).
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outs !== O_MD0) begin
      errors++;
      $display("FAIL v5_still_run: got %b expected %b", outs, O_MD0);
    end
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL v5_one_cycle_div: got %b expected %b", outs, O_IDLE);
    end
    next_cycle();
    idle();
  endtask

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  task automatic test_perf_counters();
    RESET = 1'b1;
    next_cycle();
    idle();
    next_cycle();
    RESET = 1'b0;
    checks++;
    if (STALL_CYCLES !== 32'd0 || FLUSH_EVENTS !== 32'd0) begin
      errors++;
      $display("FAIL v6_reset_counts: got %0d/%0d expected 0/0", STALL_CYCLES, FLUSH_EVENTS);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      idle();
      next_cycle();
    end
    drive(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle();
    checks++;
    if (STALL_CYCLES !== 32'd2 || FLUSH_EVENTS !== 32'd1) begin
      errors++;
      $display("FAIL v6_counts: got %0d/%0d expected 2/1", STALL_CYCLES, FLUSH_EVENTS);
    end
    dut.stall_cycles_q = 32'hFFFF_FFFF;
    drive(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle();
    checks++;
    if (STALL_CYCLES !== 32'd0) begin
      errors++;
      $display("FAIL v6_wrap: got %h expected 00000000", STALL_CYCLES);
    end
  endtask
`endif

  initial begin
    RESET = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_divide();
    test_reset_in_wait();
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports CLK and RESET.
REQ-002 CLK  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous active-high reset.
REQ-004 ID_RS1_ADDR, ID_RS2_ADDR  input  5 each  source registers of the instruction in ID.
REQ-005 ID_USES_RS1, ID_USES_RS2  input  1 each  the ID instruction actually reads RS1 / RS2.
REQ-006 EX_REG_WRITE_ADDR  input  5  destination register of the instruction in EX.
REQ-007 EX_DATA_MEM_READ  input  4  load code of the EX instruction; bit 3 set means a load.
REQ-008 EX_BRANCH_TAKEN  input  1  branch/jump in EX resolved taken this cycle.
REQ-009 EX_MULDIV_START  input  1  multi-cycle M-extension op (DIV/REM) present in EX.
REQ-010 MULDIV_DONE  input  1  the divider result is valid this cycle.
REQ-011 PC_HOLD, IF_ID_HOLD, ID_EX_HOLD  output  1 each  freeze the PC and the named pipeline registers.
REQ-012 IF_ID_FLUSH, ID_EX_FLUSH  output  1 each  load a bubble (all control fields 0) into the named register.
REQ-013 EX_MEM_BUBBLE  output  1  EX/MEM captures a bubble instead of the EX result.
REQ-014 MULDIV_BUSY  output  1  the controller is in MD_WAIT.

Function
REQ-015 The block SHALL implement a two-state FSM, RUN and MD_WAIT. All outputs SHALL be combinational (Mealy) from the state and the inputs.
REQ-016 Load-use hazard = EX_DATA_MEM_READ[3] and EX_REG_WRITE_ADDR != 0 and (ID_USES_RS1 and RS1 matches, or ID_USES_RS2 and RS2 matches).
REQ-017 In RUN with a load-use hazard and no taken branch, the block SHALL assert PC_HOLD, IF_ID_HOLD and ID_EX_FLUSH for exactly one cycle. The FSM SHALL stay in RUN.
REQ-018 In RUN with EX_BRANCH_TAKEN, the block SHALL assert IF_ID_FLUSH and ID_EX_FLUSH that cycle. A simultaneous load-use hazard SHALL be ignored, because the ID instruction is on the wrong path.
REQ-019 In RUN with EX_MULDIV_START=1 and MULDIV_DONE=0, the block SHALL assert PC_HOLD, IF_ID_HOLD, ID_EX_HOLD and EX_MEM_BUBBLE, and go to MD_WAIT.
REQ-020 EX_MULDIV_START=1 and MULDIV_DONE=1 in the same RUN cycle SHALL cause no stall, and the FSM SHALL stay in RUN.
REQ-021 In MD_WAIT with MULDIV_DONE=0, the block SHALL keep all three holds plus EX_MEM_BUBBLE asserted.
REQ-022 In MD_WAIT with MULDIV_DONE=1, the block SHALL release all holds and the bubble that same cycle, and return to RUN.
REQ-023 EX_BRANCH_TAKEN and load-use detection SHALL be ignored in MD_WAIT.
REQ-024 A HOLD and a FLUSH on the same register SHALL never be asserted together.
REQ-025 When a divide stall lasts N cycles, the total cycles from START to release SHALL be N+1.

Reset
REQ-026 RESET=1 at a rising edge SHALL force the state to RUN, including when the FSM is in MD_WAIT.
REQ-027 While RESET=1, every output SHALL be 0.
REQ-028 On the first cycle after RESET deasserts, all outputs SHALL be 0 unless inputs demand otherwise.

Configuration
REQ-029 Macro PIPELINE_CTRL_PERF_CNT_EN, when defined, SHALL add two outputs:
- STALL_CYCLES (32-bit): increments on every cycle PC_HOLD=1.
- FLUSH_EVENTS (32-bit): increments on every cycle IF_ID_FLUSH=1.
REQ-030 Both counters SHALL reset to 0 on RESET, SHALL wrap from 0xFFFFFFFF to 0, and SHALL be registered (updated at the edge after the event).
REQ-031 Without the macro, the counter ports and logic SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-032 The FSM state encodings (RUN=1'b0, MD_WAIT=1'b1) and the load-flag bit index (3) SHALL live in the shared pipeline_pkg constants file.
REQ-033 Load-use comparison SHALL be a combinational sub-module, hazard_detect, instantiated once.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- V1: EX load, rd=5; ID rs2=5, USES_RS2=1 -> PC_HOLD, IF_ID_HOLD, ID_EX_FLUSH=1 for one cycle; next cycle all 0.
- V2: same load with rd=0 -> no stall.
- V3: V1 plus EX_BRANCH_TAKEN in the same cycle -> IF_ID_FLUSH and ID_EX_FLUSH=1, PC_HOLD=0.
- V4: EX_MULDIV_START at cycle 0, MULDIV_DONE at cycle 33 -> holds, EX_MEM_BUBBLE and MULDIV_BUSY (from cycle 1) for cycles 0-32; all 0 at cycle 33; FSM in RUN at cycle 34.
- V5: RESET at cycle 10 of a divide stall -> outputs 0 during reset; FSM in RUN; no hold after release. START and DONE together -> no stall.
- V6 (macro on): V1 twice plus V3 once -> STALL_CYCLES=2, FLUSH_EVENTS=1; preload 0xFFFFFFFF, then one stall -> 0.
